// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg
//   Shared types and constants for the FPU issue controller slice.
//   - fpu_state_t     : controller FSM states (IDLE, EXEC, HOLD)
//   - fpu_issue_t     : packed view of the decode-stage FP op fields
//   - FPU_LATENCY_DEF : default FPU pipeline latency in cycles
//   - CNT_W           : width of the latency down-counter (covers 1..15)
package fpu_issue_ctrl_pkg;

  localparam int FPU_LATENCY_DEF = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } fpu_state_t;

  typedef struct packed {
    logic       valid;
    logic       rd;
    logic       wr;
    logic [4:0] fs_a;
    logic [4:0] ft_a;
    logic [4:0] fd_a;
  } fpu_issue_t;

  // True when a decode register address names the register still owed by
  // the op in flight.
  function automatic logic pend_hit(input logic [4:0] pend_fd,
                                    input logic [4:0] addr);
    return pend_fd == addr;
  endfunction

endpackage

// File: rtl/fpu_latency_counter.sv
// fpu_latency_counter
//   Loadable down-counter that times the FPU pipeline.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     load         : load load_val this cycle (wins over dec)
//     load_val     : value to load
//     dec          : decrement by one; saturates at zero
//     zero         : counter currently reads zero
module fpu_latency_counter
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Issue/hazard controller for a single-op-in-flight FPU. Launches an FPU
//   op from decode, times its latency, holds the result until the FP write
//   port is free (lwc1 writeback from M always wins) and stalls decode on
//   structural, RAW and WAW hazards against the pending destination.
//
//   Optional feature: define FPU_FWD_EN to forward the held result to decode
//   in the writeback cycle (adds fwd_val/fwd_fs/fwd_ft, removes the RAW stall
//   for that cycle).
//
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     id_fp_valid          : decode holds an FPU arithmetic op
//     id_fp_rd / id_fp_wr  : decode op reads fs/ft / writes an FP register
//     id_fs_a/ft_a/fd_a    : decode FP register addresses
//     mem_fp_wb_req        : M-stage lwc1 owns the FP write port this cycle
//     fpu_result           : FPU datapath result
//     fpu_start            : one-cycle launch pulse to the FPU
//     stall_d              : stall decode/IF
//     fp_wb_en/dst/val     : FP register-file write port (FPU side)
//     busy                 : controller is not IDLE
//     dbg_state            : current FSM state
//     fwd_val/fs/ft        : (FPU_FWD_EN) forwarded result and source flags
//
//   Issue handshake: id_fp_valid is the valid, !stall_d is the ready; an op
//   transfers (fpu_start pulses) in exactly the cycle both are high, and
//   decode must hold the op unchanged while stalled.
//
//   FPU_LATENCY must lie in 1..15.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int FPU_LATENCY = FPU_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_fp_valid,
  input  logic        id_fp_rd,
  input  logic        id_fp_wr,
  input  logic [4:0]  id_fs_a,
  input  logic [4:0]  id_ft_a,
  input  logic [4:0]  id_fd_a,
  input  logic        mem_fp_wb_req,
  input  logic [31:0] fpu_result,
  output logic        fpu_start,
  output logic        stall_d,
  output logic        fp_wb_en,
  output logic [4:0]  fp_wb_dst,
  output logic [31:0] fp_wb_val,
  output logic        busy,
  output logic [1:0]  dbg_state
`ifdef FPU_FWD_EN
  ,
  output logic [31:0] fwd_val,
  output logic        fwd_fs,
  output logic        fwd_ft
`endif
);

  fpu_state_t state_q, state_d;
  fpu_issue_t id_op;

  logic [4:0]  pend_fd_q;
  logic [31:0] res_q;

  logic cnt_zero;
  logic in_exec, in_hold, pend_active;
  logic grant, wb_fire;
  logic hit_fs, hit_ft;
  logic struct_stall, raw_stall, waw_stall, stall;
  logic issue;

  assign id_op = '{valid: id_fp_valid, rd: id_fp_rd, wr: id_fp_wr,
                   fs_a: id_fs_a, ft_a: id_ft_a, fd_a: id_fd_a};

  // ------------------------------------------------------------------
  // Hazard detection (purely combinational from state and inputs)
  // ------------------------------------------------------------------
  always_comb begin
    in_exec     = (state_q == EXEC);
    in_hold     = (state_q == HOLD);
    // The pending destination only means something while an op is owed.
    pend_active = in_exec || in_hold;
    grant       = !mem_fp_wb_req;
    wb_fire     = in_hold && grant;

    hit_fs = id_op.rd && pend_hit(pend_fd_q, id_op.fs_a);
    hit_ft = id_op.rd && pend_hit(pend_fd_q, id_op.ft_a);

    // A new FPU op cannot launch while the unit or its result slot is busy;
    // the slot frees only in the cycle the result wins the write port.
    struct_stall = id_op.valid && (in_exec || (in_hold && !grant));

`ifdef FPU_FWD_EN
    // In the writeback cycle the held result is forwarded, so readers go on.
    raw_stall = pend_active && (hit_fs || hit_ft) && !wb_fire;
`else
    raw_stall = pend_active && (hit_fs || hit_ft);
`endif

    // Even in the writeback cycle a younger writer to the same register is
    // held back so the two writes can never be reordered.
    waw_stall = pend_active && id_op.wr && pend_hit(pend_fd_q, id_op.fd_a);

    stall = struct_stall || raw_stall || waw_stall;

    // Issue from IDLE, or from HOLD in the cycle the slot is released.
    issue = id_op.valid && !stall && ((state_q == IDLE) || wb_fire);
  end

  // ------------------------------------------------------------------
  // Latency counter
  // ------------------------------------------------------------------
  fpu_latency_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue),
    .load_val (CNT_W'(FPU_LATENCY - 1)),
    .dec      (in_exec),
    .zero     (cnt_zero)
  );

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_zero) state_d = HOLD;
      end
      HOLD: begin
        if (wb_fire) state_d = issue ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    fpu_start = issue;
    stall_d   = stall;
    fp_wb_en  = wb_fire;
    fp_wb_dst = pend_fd_q;
    fp_wb_val = res_q;
    busy      = (state_q != IDLE);
    dbg_state = state_q;
`ifdef FPU_FWD_EN
    fwd_val = res_q;
    fwd_fs  = wb_fire && hit_fs;
    fwd_ft  = wb_fire && hit_ft;
`endif
  end

  // ------------------------------------------------------------------
  // Pending destination and result holding register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_fd_q <= '0;
      res_q     <= '0;
    end else begin
      if (issue) begin
        pend_fd_q <= id_op.fd_a;
      end
      // The FPU result is valid only in the last EXEC cycle; capture it
      // there and keep it for as long as the write port is denied.
      if (in_exec && cnt_zero) begin
        res_q <= fpu_result;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  localparam int L = 4;
`ifdef FPU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        id_fp_valid, id_fp_rd, id_fp_wr;
  logic [4:0]  id_fs_a, id_ft_a, id_fd_a;
  logic        mem_fp_wb_req;
  logic [31:0] fpu_result;
  logic        fpu_start, stall_d, fp_wb_en, busy;
  logic [4:0]  fp_wb_dst;
  logic [31:0] fp_wb_val;
  logic [1:0]  dbg_state;
`ifdef FPU_FWD_EN
  logic [31:0] fwd_val;
  logic        fwd_fs, fwd_ft;
`endif

  fpu_issue_ctrl #(.FPU_LATENCY(L)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_fp_valid   (id_fp_valid),
    .id_fp_rd      (id_fp_rd),
    .id_fp_wr      (id_fp_wr),
    .id_fs_a       (id_fs_a),
    .id_ft_a       (id_ft_a),
    .id_fd_a       (id_fd_a),
    .mem_fp_wb_req (mem_fp_wb_req),
    .fpu_result    (fpu_result),
    .fpu_start     (fpu_start),
    .stall_d       (stall_d),
    .fp_wb_en      (fp_wb_en),
    .fp_wb_dst     (fp_wb_dst),
    .fp_wb_val     (fp_wb_val),
    .busy          (busy),
    .dbg_state     (dbg_state)
`ifdef FPU_FWD_EN
    ,
    .fwd_val       (fwd_val),
    .fwd_fs        (fwd_fs),
    .fwd_ft        (fwd_ft)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic [36:0] exp_q[$];   // expected {dst, val} writebacks, in order
  int start_q[$];
  int wb_q[$];
  int busy_cnt;
  int stall_cnt;
  logic [31:0] fwd_seen_val;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // One op at most is owed. m_age counts cycles since its launch: it is
  // executing for ages 1..L (the FPU result appears at age L) and waits for
  // the write port afterwards.
  logic        m_inflight;
  int          m_age;
  logic [4:0]  m_fd;
  logic [31:0] m_res;

  logic e_exec, e_wait, e_wb, e_stall, e_start, e_busy, e_fwd_fs, e_fwd_ft;

  always_comb begin
    logic hit_fs, hit_ft, raw, waw, strc;
    e_exec   = m_inflight && (m_age <= L);
    e_wait   = m_inflight && (m_age > L);
    e_wb     = e_wait && !mem_fp_wb_req;
    hit_fs   = m_inflight && id_fp_rd && (m_fd == id_fs_a);
    hit_ft   = m_inflight && id_fp_rd && (m_fd == id_ft_a);
    raw      = (hit_fs || hit_ft) && !(FWD && e_wb);
    waw      = m_inflight && id_fp_wr && (m_fd == id_fd_a);
    strc     = id_fp_valid && (e_exec || (e_wait && mem_fp_wb_req));
    e_stall  = raw || waw || strc;
    e_start  = id_fp_valid && !e_stall;
    e_busy   = m_inflight;
    e_fwd_fs = FWD && e_wb && hit_fs;
    e_fwd_ft = FWD && e_wb && hit_ft;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_age      <= 0;
      m_fd       <= '0;
      m_res      <= '0;
    end else begin
      if (m_inflight && (m_age == L)) m_res <= fpu_result;
      if (e_start) begin
        m_inflight <= 1'b1;
        m_age      <= 1;
        m_fd       <= id_fd_a;
      end else if (e_wb) begin
        m_inflight <= 1'b0;
      end else if (m_inflight) begin
        m_age <= m_age + 1;
      end
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      40'(busy),      40'(e_busy));
      check("fpu_start", 40'(fpu_start), 40'(e_start));
      check("stall_d",   40'(stall_d),   40'(e_stall));
      check("fp_wb_en",  40'(fp_wb_en),  40'(e_wb));
      if (e_wb) begin
        check("fp_wb_dst", 40'(fp_wb_dst), 40'(m_fd));
        check("fp_wb_val", 40'(fp_wb_val), 40'(m_res));
      end
`ifdef FPU_FWD_EN
      check("fwd_fs", 40'(fwd_fs), 40'(e_fwd_fs));
      check("fwd_ft", 40'(fwd_ft), 40'(e_fwd_ft));
      if (e_fwd_fs || e_fwd_ft) check("fwd_val", 40'(fwd_val), 40'(m_res));
      if (fwd_fs) fwd_seen_val = fwd_val;
`endif
      if (fpu_start) start_q.push_back(cyc);
      if (busy)      busy_cnt++;
      if (stall_d)   stall_cnt++;
      if (fp_wb_en) begin
        wb_q.push_back(cyc);
        check("sb_expected", 40'(exp_q.size() > 0), 40'(1));
        if (exp_q.size() > 0) check("sb_wb", 40'({fp_wb_dst, fp_wb_val}), 40'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr,
                        input logic [4:0] fs, input logic [4:0] ft,
                        input logic [4:0] fd, input logic mem);
    id_fp_valid   = v;
    id_fp_rd      = rd;
    id_fp_wr      = wr;
    id_fs_a       = fs;
    id_ft_a       = ft;
    id_fd_a       = fd;
    mem_fp_wb_req = mem;
  endtask

  task automatic idle_in();
    set_op(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Hold the currently driven op until it launches (bounded).
  task automatic hold_until_start(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (fpu_start) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("start_timeout", 40'(ok), 40'(1));
    idle_in();
  endtask

  task automatic clear_logs();
    start_q.delete();
    wb_q.delete();
    busy_cnt     = 0;
    stall_cnt    = 0;
    fwd_seen_val = '0;
  endtask

  function automatic int gap(input int a, input int b);
    return b - a;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    idle_in();
    fpu_result = '0;
    rst_n      = 1'b0;
    clear_logs();
    step(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy",      40'(busy),      40'(0));
    check("rst_fpu_start", 40'(fpu_start), 40'(0));
    check("rst_fp_wb_en",  40'(fp_wb_en),  40'(0));
    check("rst_stall_d",   40'(stall_d),   40'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // T1: single op, fd=3, latency L+1 to writeback, busy cycles 1..5
    clear_logs();
    fpu_result = 32'h40490FDB;
    exp_q.push_back({5'd3, 32'h40490FDB});
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    step(1);
    idle_in();
    step(8);
    check("t1_nwb",        40'(wb_q.size()), 40'(1));
    check("t1_latency",    40'(gap(start_q[0], wb_q[0])), 40'(5));
    check("t1_busy_cycles", 40'(busy_cnt), 40'(5));

    // T2: dependent op reading f3 right behind the fd=3 op
    clear_logs();
    fpu_result = 32'h40490FDB;
    exp_q.push_back({5'd3, 32'h40490FDB});
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    step(1);
    set_op(1, 1, 1, 5'd3, 5'd1, 5'd5, 0);
    hold_until_start(12);
    fpu_result = 32'h3F800000;
    exp_q.push_back({5'd5, 32'h3F800000});
    step(8);
`ifdef FPU_FWD_EN
    check("t2_start_gap",   40'(gap(start_q[0], start_q[1])), 40'(5));
    check("t2_stall_cycles", 40'(stall_cnt), 40'(4));
    check("t2_fwd_val",     40'(fwd_seen_val), 40'(32'h40490FDB));
`else
    check("t2_start_gap",   40'(gap(start_q[0], start_q[1])), 40'(6));
    check("t2_stall_cycles", 40'(stall_cnt), 40'(5));
`endif

    // T3: lwc1 owns the write port for 3 cycles from HOLD entry
    clear_logs();
    fpu_result = 32'h12345678;
    exp_q.push_back({5'd4, 32'h12345678});
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd4, 0);
    step(1);
    idle_in();
    step(4);
    mem_fp_wb_req = 1'b1;
    fpu_result    = 32'hDEADBEEF;
    step(3);
    mem_fp_wb_req = 1'b0;
    step(4);
    check("t3_nwb",     40'(wb_q.size()), 40'(1));
    check("t3_latency", 40'(gap(start_q[0], wb_q[0])), 40'(8));

    // T4: back-to-back independent ops (fd=3, then fd=7 reading f1,f2)
    clear_logs();
    fpu_result = 32'hAAAA0001;
    exp_q.push_back({5'd3, 32'hAAAA0001});
    set_op(1, 0, 1, 5'd0, 5'd0, 5'd3, 0);
    step(1);
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd7, 0);
    hold_until_start(12);
    fpu_result = 32'hBBBB0002;
    exp_q.push_back({5'd7, 32'hBBBB0002});
    step(8);
    check("t4_start_gap", 40'(gap(start_q[0], start_q[1])), 40'(5));
    check("t4_no_idle",   40'(gap(wb_q[0], start_q[1])), 40'(0));
    check("t4_nwb",       40'(wb_q.size()), 40'(2));

    // T5: lwc1 to f3 decoded while the fd=3 op executes
    clear_logs();
    fpu_result = 32'h00C0FFEE;
    exp_q.push_back({5'd3, 32'h00C0FFEE});
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    step(1);
    set_op(0, 0, 1, 5'd0, 5'd0, 5'd3, 0);
    step(8);
    idle_in();
    step(2);
    check("t5_stall_cycles", 40'(stall_cnt), 40'(5));

    // T6: WAW on the same destination back to back
    clear_logs();
    fpu_result = 32'h11110003;
    exp_q.push_back({5'd3, 32'h11110003});
    set_op(1, 0, 1, 5'd0, 5'd0, 5'd3, 0);
    step(1);
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    hold_until_start(12);
    fpu_result = 32'h22220004;
    exp_q.push_back({5'd3, 32'h22220004});
    step(8);
    check("t6_start_gap", 40'(gap(start_q[0], start_q[1])), 40'(6));

    // T7: reset in EXEC (counter at 2) abandons the op
    clear_logs();
    fpu_result = 32'h55555555;
    set_op(1, 1, 1, 5'd1, 5'd2, 5'd3, 0);
    step(1);
    idle_in();
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_busy_in_rst", 40'(busy),     40'(0));
    check("t7_wb_in_rst",   40'(fp_wb_en), 40'(0));
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t7_no_wb", 40'(wb_q.size()), 40'(0));

    check("sb_drained", 40'(exp_q.size()), 40'(0));
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter FPU_LATENCY, default 4, giving cycles from fpu_start to a valid fpu_result (legal range 1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 id_fp_valid  in  1  decode holds an FPU arithmetic op (FRType).
REQ-005 id_fp_rd  in  1  decode op reads FP registers fs/ft (FPU op or swc1).
REQ-006 id_fp_wr  in  1  decode op writes an FP register (FPU op or lwc1).
REQ-007 id_fs_a, id_ft_a, id_fd_a  in  5 each  decode FP register addresses (RegAddr).
REQ-008 mem_fp_wb_req  in  1  M-stage lwc1 needs the FP write port this cycle.
REQ-009 fpu_result  in  32  FPU datapath result (Register).
REQ-010 fpu_start  out  1  one-cycle launch pulse to the FPU.
REQ-011 stall_d  out  1  stall decode/IF this cycle.
REQ-012 fp_wb_en, fp_wb_dst, fp_wb_val  out  1/5/32  FP register-file write port from the FPU side.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and HOLD; one op in flight at most.
REQ-015 IDLE: when id_fp_valid and not stall_d, it SHALL assert fpu_start, latch id_fd_a as pend_fd, load cnt=FPU_LATENCY-1 and go to EXEC.
REQ-016 EXEC: cnt SHALL decrement each cycle; at cnt==0 it SHALL capture fpu_result into res_q and go to HOLD.
REQ-017 HOLD: grant = not mem_fp_wb_req; when granted it SHALL drive fp_wb_en=1, fp_wb_dst=pend_fd, fp_wb_val=res_q for exactly that cycle.
REQ-018 HOLD with grant and no issuable op SHALL go to IDLE; HOLD with grant and an issuable op SHALL issue (REQ-015 actions) and go directly to EXEC.
REQ-019 HOLD without grant SHALL stay in HOLD with res_q held; lwc1 always has port priority.
REQ-020 Structural stall: stall_d SHALL be 1 when id_fp_valid and the state is EXEC, or HOLD without grant.
REQ-021 RAW stall: stall_d SHALL be 1 when id_fp_rd and pend_fd equals id_fs_a or id_ft_a while in EXEC, or in HOLD (subject to REQ-026).
REQ-022 WAW stall: stall_d SHALL be 1 when id_fp_wr and id_fd_a equals pend_fd while in EXEC or HOLD.
REQ-023 The pending-register compare SHALL be inactive in IDLE; stall_d SHALL be combinational from current state and inputs.
REQ-024 Total result latency, fpu_start to fp_wb_en, SHALL be FPU_LATENCY+1 cycles absent port contention.

Reset
REQ-025 While rst_n is low: state=IDLE, cnt=0, pend_fd=0, res_q=0, and fpu_start, stall_d (register part), fp_wb_en and busy SHALL be 0; an op in EXEC/HOLD is abandoned with no writeback.

Configuration
REQ-026 With FPU_FWD_EN defined: in HOLD with grant, a RAW match on pend_fd SHALL NOT stall, and output fwd_val (32) SHALL carry res_q with fwd_fs/fwd_ft (1 each) flagging the matching source; without FPU_FWD_EN these ports are absent and the RAW stall holds for that cycle too.

Structure
REQ-027 The shared package SHALL hold the FpuState enum (IDLE, EXEC, HOLD), the FPU_LATENCY default constant, and a packed FPU_issue struct (valid, rd, wr, fs_a, ft_a, fd_a).
REQ-028 The down-counter SHALL be a sub-module fpu_latency_counter (load, dec, zero flag).

Verification
REQ-029 Single op, FPU_LATENCY=4, fd=3, fpu_result=0x40490FDB -> fpu_start at cycle 0; fp_wb_en at cycle 5 with dst=3, val=0x40490FDB; busy 1 for cycles 1-5.
REQ-030 Dependent op reading f3 right after REQ-029 op -> stall_d high through cycle 4; cycle 5 stalls only without FPU_FWD_EN; with FPU_FWD_EN fwd_fs=1, fwd_val=0x40490FDB.
REQ-031 mem_fp_wb_req held high for 3 cycles from entry to HOLD -> fp_wb_en stays 0, res_q unchanged; writeback in the 4th cycle.
REQ-032 Back-to-back independent ops (fd=3, then fd=7 reading f1,f2) -> second fpu_start in the cycle the first writes back; no idle cycle.
REQ-033 lwc1 to f3 decoded during EXEC of op with fd=3 -> stall_d high until the FPU writeback cycle.
REQ-034 rst_n pulled low in EXEC with cnt=2 -> state IDLE, busy 0, no fp_wb_en after rst_n returns high.
